// File: rtl/avalon_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_ram_pkg
// Description : Shared types and constants for the wait-state Avalon RAM:
//               transfer FSM state encoding, default geometry/latency and
//               the wait-count LFSR seed and feedback taps.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_ram_pkg;

    // Transfer sequencing: IDLE -> (WAIT) -> ACK -> IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int c_DEFAULT_ADDR_W      = 8;
    localparam int c_DEFAULT_WAIT_CYCLES = 1;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
    localparam logic [7:0] c_LFSR_SEED = 8'h01;
    localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

endpackage
`default_nettype wire

// File: rtl/wait_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : wait_lfsr
// Description : 8-bit maximal-length Fibonacci LFSR used to randomise the
//               per-transfer wait count. Steps once per advance pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_lfsr
    import avalon_ram_pkg::*;
#(
    parameter logic [7:0] SEED = c_LFSR_SEED,
    parameter logic [7:0] TAPS = c_LFSR_TAPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;

    // Shift left, feeding the XOR of the tapped bits back into bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & TAPS)};
        end
    end

    assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/avalon_wait_ram.sv
`default_nettype none
// ============================================================================
// Module      : avalon_wait_ram
// Description : Single-port 32-bit Avalon-MM RAM that stretches every bus
//               transfer with a programmable number of wait states, plus a
//               synchronous full-word preload port that survives reset.
//               Optional: define AVALON_RAM_RANDOM_WAIT_EN to draw each
//               transfer's wait count from an LFSR (mod WAIT_CYCLES+1).
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_wait_ram
    import avalon_ram_pkg::*;
#(
    parameter int ADDR_W      = c_DEFAULT_ADDR_W,
    parameter int WAIT_CYCLES = c_DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    input  logic              inst_input,
    input  logic [ADDR_W+1:0] inst_addr,
    input  logic [31:0]       instruction
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [c_DEPTH];
    state_t            r_state;
    logic [3:0]        r_count;
    logic [31:0]       r_readdata;

    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_inst_word;
    logic              w_req;
    logic              w_accept;
    logic              w_abort;
    logic              w_enter_ack;
    logic              w_load_rd;
    logic              w_commit_wr;
    logic [3:0]        w_wait_load;
    logic              w_unused;

    assign w_word      = address[ADDR_W+1:2];
    assign w_inst_word = inst_addr[ADDR_W+1:2];
    assign w_req       = read | write;

    // Preload owns the array: it freezes the FSM in IDLE and cancels any
    // transfer already in flight, so a same-cycle bus write can never win.
    assign w_accept    = (r_state == IDLE) && w_req && !inst_input;
    assign w_abort     = !w_req || inst_input;
    assign w_enter_ack = w_req && !inst_input &&
                         (((r_state == IDLE) && (w_wait_load == 4'd0)) ||
                          ((r_state == WAIT) && (r_count <= 4'd1)));
    assign w_load_rd   = w_enter_ack && read && !write;
    assign w_commit_wr = (r_state == ACK) && write && !inst_input;

    // Byte-offset and out-of-range address bits are don't-care by design.
    assign w_unused = ^{address[31:ADDR_W+2], address[1:0], inst_addr[1:0]};

`ifdef AVALON_RAM_RANDOM_WAIT_EN
    logic [7:0] w_lfsr;
    logic       w_lfsr_unused;

    wait_lfsr #(
        .SEED (c_LFSR_SEED),
        .TAPS (c_LFSR_TAPS)
    ) u_wait_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_accept),
        .value   (w_lfsr)
    );

    // Five-bit modulus so WAIT_CYCLES=15 (divisor 16) still fits.
    assign w_wait_load   = 4'({1'b0, w_lfsr[3:0]} % 5'(WAIT_CYCLES + 1));
    assign w_lfsr_unused = ^w_lfsr[7:4];
`else
    assign w_wait_load = 4'(WAIT_CYCLES);
`endif

    // Transfer sequencer: IDLE spends one stalled cycle, WAIT the loaded count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_wait_load == 4'd0) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= WAIT;
                            r_count <= w_wait_load;
                        end
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (r_count <= 4'd1) begin
                        r_state <= ACK;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Capture the addressed word as a pure read enters ACK; hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (w_load_rd) begin
            r_readdata <= r_mem[w_word];
        end
    end

    // Storage is never reset; byte-lane bus writes, then preload overrides.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    r_mem[w_word][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
        if (inst_input) begin
            r_mem[w_inst_word] <= instruction;
        end
    end

    // Stall any pending request except during the single ACK cycle.
    always_comb begin
        waitrequest = 1'b0;
        if (reset) begin
            waitrequest = w_req && ((r_state != ACK) || inst_input);
        end
    end

    assign readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_wait_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_wait_ram
// Description : Self-checking bench for avalon_wait_ram. Three instances
//               (WAIT_CYCLES = 1, 0, 7) are driven by a transfer-level
//               master model; a per-cycle compare process checks
//               waitrequest and readdata against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_wait_ram;

    localparam int AW   = 8;
    localparam int NDUT = 3;
    localparam int DEP  = 1 << AW;

    function automatic int wc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 7;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   address [NDUT];
    logic          rd      [NDUT];
    logic          wr      [NDUT];
    logic [31:0]   wdata   [NDUT];
    logic [3:0]    be      [NDUT];
    logic          wreq    [NDUT];
    logic [31:0]   rdata   [NDUT];
    logic          inst_in [NDUT];
    logic [AW+1:0] inst_a  [NDUT];
    logic [31:0]   instr   [NDUT];

    // Reference state
    logic [31:0] mem_m  [NDUT][DEP];
    logic [31:0] rd_m   [NDUT];
    logic [7:0]  lfsr_m [NDUT];
    logic        exp_wr [NDUT];
    int          hi_cnt [NDUT];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    avalon_wait_ram #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(reset), .address(address[0]), .read(rd[0]), .write(wr[0]),
        .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
        .inst_input(inst_in[0]), .inst_addr(inst_a[0]), .instruction(instr[0]));

    avalon_wait_ram #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .address(address[1]), .read(rd[1]), .write(wr[1]),
        .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
        .inst_input(inst_in[1]), .inst_addr(inst_a[1]), .instruction(instr[1]));

    avalon_wait_ram #(.ADDR_W(AW), .WAIT_CYCLES(7)) u_dut2 (
        .clk(clk), .reset(reset), .address(address[2]), .read(rd[2]), .write(wr[2]),
        .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
        .inst_input(inst_in[2]), .inst_addr(inst_a[2]), .instruction(instr[2]));

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (wreq[d] !== exp_wr[d]) begin
                    errors++;
                    $display("FAIL waitrequest dut%0d t=%0t got=%b exp=%b", d, $time, wreq[d], exp_wr[d]);
                end
                checks++;
                if (rdata[d] !== rd_m[d]) begin
                    errors++;
                    $display("FAIL readdata dut%0d t=%0t got=%h exp=%h", d, $time, rdata[d], rd_m[d]);
                end
                if (wreq[d] === 1'b1) hi_cnt[d]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] bev);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (bev[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Number of waitrequest-high cycles the next accepted transfer must show
    task automatic stall_count(input int d, output int n);
`ifdef AVALON_RAM_RANDOM_WAIT_EN
        n = (int'(lfsr_m[d][3:0]) % (wc_of(d) + 1)) + 1;
        lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
`else
        n = wc_of(d) + 1;
`endif
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            rd_m[d]   = 32'h0;
            lfsr_m[d] = 8'h01;
            exp_wr[d] = 1'b0;
        end
    endtask

    task automatic release_bus(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0; inst_in[d] = 1'b0; exp_wr[d] = 1'b0;
    endtask

    // One complete bus transfer; returns just after its ACK edge
    task automatic xfer(input int d, input logic is_rd, input logic is_wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bev);
        int n;
        address[d] = a; rd[d] = is_rd; wr[d] = is_wr; wdata[d] = wd; be[d] = bev;
        inst_in[d] = 1'b0;
        stall_count(d, n);
        for (int k = 0; k < n; k++) begin
            exp_wr[d] = 1'b1;
            step();
        end
        exp_wr[d] = 1'b0;
        if (is_rd && !is_wr) rd_m[d] = mem_m[d][a[AW+1:2]];
        step();
        if (is_wr) mem_m[d][a[AW+1:2]] = merge(mem_m[d][a[AW+1:2]], wd, bev);
    endtask

    // One preload cycle; any request already on the bus must stay stalled
    task automatic preload(input int d, input logic [31:0] a, input logic [31:0] data);
        inst_in[d] = 1'b1; inst_a[d] = a[AW+1:0]; instr[d] = data;
        exp_wr[d]  = rd[d] | wr[d];
        step();
        mem_m[d][a[AW+1:2]] = data;
        inst_in[d] = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin : stim
        int n, d, burst, op, np;
        logic [31:0] a, v;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
        int lit_hi [3];
        lit_hi[0] = 2; lit_hi[1] = 3; lit_hi[2] = 5;
`endif
        for (int i = 0; i < NDUT; i++) begin
            address[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0; be[i] = '0;
            inst_in[i] = 1'b0; inst_a[i] = '0; instr[i] = '0; hi_cnt[i] = 0;
        end
        model_reset();
        #2 reset = 1'b0;
        chk_en = 1'b1;
        step(); step(); step();
        reset = 1'b1;
        step();

        // Fill every word of every instance through the preload port
        for (int w = 0; w < DEP; w++) begin
            for (int i = 0; i < NDUT; i++) begin
                inst_in[i] = 1'b1;
                inst_a[i]  = {w[AW-1:0], 2'(i)};
                instr[i]   = $urandom();
            end
            step();
            for (int i = 0; i < NDUT; i++) mem_m[i][w] = instr[i];
        end
        for (int i = 0; i < NDUT; i++) release_bus(i);

        // Preloaded program survives reset; WC=1 read stalls 2 cycles
        preload(0, 32'h04, 32'h24020010);
        release_bus(0);
        reset_pulse();
        hi_cnt[0] = 0;
        xfer(0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        check("req033_stall_cycles", 32'(hi_cnt[0]), 32'd2);
        check("req033_readdata", rdata[0], 32'h24020010);
        release_bus(0);
        step();

`ifdef AVALON_RAM_RANDOM_WAIT_EN
        // Seed 0x01 gives wait counts 1, 2, 4 for WAIT_CYCLES=7
        for (int k = 0; k < 3; k++) begin
            hi_cnt[2] = 0;
            xfer(2, 1'b1, 1'b0, $urandom(), 32'h0, 4'h0);
            check("req038_lfsr_stall", 32'(hi_cnt[2]), 32'(lit_hi[k]));
        end
        release_bus(2);
        step();
`endif

        // Byte-lane write merge
        preload(0, 32'h10, 32'h11223344);
        xfer(0, 1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("req034_byteenable_merge", rdata[0], 32'h11BB33DD);
        release_bus(0);
        step();

        // Zero wait states, back-to-back reads
        preload(1, 32'h08, 32'hCAFE0008);
        preload(1, 32'h0C, 32'hBEEF000C);
        hi_cnt[1] = 0;
        xfer(1, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        check("req035_stall_first", 32'(hi_cnt[1]), 32'd1);
        check("req035_data_first", rdata[1], 32'hCAFE0008);
        hi_cnt[1] = 0;
        xfer(1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        check("req035_stall_second", 32'(hi_cnt[1]), 32'd1);
        check("req035_data_second", rdata[1], 32'hBEEF000C);
        release_bus(1);
        step();

        // Dropped write, then reset in the middle of a write
        preload(0, 32'h20, 32'h0BADF00D);
        address[0] = 32'h20; wr[0] = 1'b1; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
        stall_count(0, n);
        exp_wr[0] = 1'b1;
        step();
        wr[0] = 1'b0; exp_wr[0] = 1'b0;
        step();
        step();
        wr[0] = 1'b1;
        stall_count(0, n);
        exp_wr[0] = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        step();
        step();
        release_bus(0);
        reset = 1'b1;
        step();
        xfer(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        check("req036_word_preserved", rdata[0], 32'h0BADF00D);
        release_bus(0);
        step();

        // Address wrap, then a read stalled behind preload
        xfer(0, 1'b0, 1'b1, 32'h404, 32'h00000055, 4'hF);
        xfer(0, 1'b1, 1'b0, 32'h004, 32'h0, 4'h0);
        check("req037_wrap", rdata[0], 32'h00000055);
        hi_cnt[0] = 0;
        address[0] = 32'h008; rd[0] = 1'b1; wr[0] = 1'b0;
        for (int k = 0; k < 3; k++) preload(0, 32'h100, $urandom());
        xfer(0, 1'b1, 1'b0, 32'h008, 32'h0, 4'h0);
`ifndef AVALON_RAM_RANDOM_WAIT_EN
        check("req037_preload_stall", 32'(hi_cnt[0]), 32'd5);
`endif
        release_bus(0);
        step();

        // Randomised bursts on randomly chosen instances
        for (int it = 0; it < 300; it++) begin
            d = $urandom_range(0, NDUT - 1);
            burst = $urandom_range(1, 3);
            for (int b = 0; b < burst; b++) begin
                op = $urandom_range(0, 4);
                a  = $urandom();
                v  = $urandom();
                case (op)
                    0: xfer(d, 1'b1, 1'b0, a, v, 4'($urandom()));
                    1: xfer(d, 1'b0, 1'b1, a, v, 4'($urandom()));
                    2: xfer(d, 1'b1, 1'b1, a, v, 4'($urandom()));
                    3: begin
                        address[d] = a; rd[d] = 1'b1; wr[d] = 1'b0;
                        np = $urandom_range(1, 2);
                        for (int k = 0; k < np; k++) begin
                            // Sometimes preload the very word being read
                            if ($urandom_range(0, 1) == 1) preload(d, a, $urandom());
                            else preload(d, $urandom(), $urandom());
                        end
                        xfer(d, 1'b1, 1'b0, a, v, 4'h0);
                    end
                    default: begin
                        release_bus(d);
                        preload(d, a, v);
                    end
                endcase
            end
            release_bus(d);
            if ($urandom_range(0, 1) == 1) step();
        end

        for (int i = 0; i < NDUT; i++) release_bus(i);
        step(); step(); step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
